// File: rtl/ppg_window_stats_pkg.sv
// Shared definitions for the PPG window statistics block:
// default widths and the control FSM state encoding.
package ppg_window_stats_pkg;
   localparam int ADC_W_DEF    = 8;
   localparam int WIN_LOG2_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;
endpackage

// File: rtl/ppg_channel_stats.sv
// Running max/min/sum/clip for one ADC channel over a window.
// Outputs are the post-accept values, so the top can capture a window including its final sample.
module ppg_channel_stats #(
   parameter int ADC_W = 8,
   parameter int SUM_W = 16
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_accept,
   input  logic [ADC_W-1:0] i_sample,
   output logic [ADC_W-1:0] o_max,
   output logic [ADC_W-1:0] o_min,
   output logic [SUM_W-1:0] o_sum,
   output logic             o_clip
);
   logic [ADC_W-1:0] r_max, r_min;
   logic [SUM_W-1:0] r_sum;
   logic             r_clip;
   logic             w_full_scale;

   assign w_full_scale = (i_sample == '0) || (i_sample == '1);

   always_comb begin
      o_max  = r_max;
      o_min  = r_min;
      o_sum  = r_sum;
      o_clip = r_clip;
      if (i_accept) begin
         if (i_start) begin
            o_max  = i_sample;
            o_min  = i_sample;
            o_sum  = SUM_W'(i_sample);
            o_clip = w_full_scale;
         end else begin
            if (i_sample > r_max) o_max = i_sample;
            if (i_sample < r_min) o_min = i_sample;
            o_sum  = r_sum + SUM_W'(i_sample);
            o_clip = r_clip | w_full_scale;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_max  <= '0;
         r_min  <= '0;
         r_sum  <= '0;
         r_clip <= 1'b0;
      end else if (i_accept) begin
         r_max  <= o_max;
         r_min  <= o_min;
         r_sum  <= o_sum;
         r_clip <= o_clip;
      end
   end
endmodule

// File: rtl/ppg_window_stats.sv
// Per-window AC/DC extractor for the IR and RED pulse-oximeter channels.
// Publishes max-min, mean and a clip flag every 2**WIN_LOG2 accepted samples.
module ppg_window_stats
   import ppg_window_stats_pkg::*;
#(
   parameter int ADC_W    = ADC_W_DEF,
   parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             Settings_Locked,
   input  logic             Sample_Valid,
   input  logic [ADC_W-1:0] IR_ADC_Value,
   input  logic [ADC_W-1:0] RED_ADC_Value,
   output logic             Out_Valid,
   output logic [ADC_W-1:0] IR_AC,
   output logic [ADC_W-1:0] RED_AC,
   output logic [ADC_W-1:0] IR_DC,
   output logic [ADC_W-1:0] RED_DC,
   output logic             IR_Clip,
   output logic             RED_Clip,
   output logic             Busy
);
   localparam int SUM_W = ADC_W + WIN_LOG2;

   state_t              r_state, w_state_nxt;
   logic [WIN_LOG2-1:0] r_cnt;
   logic                w_accept, w_start, w_last;

   logic [ADC_W-1:0] w_ir_max, w_ir_min, w_red_max, w_red_min;
   logic [SUM_W-1:0] w_ir_sum, w_red_sum;
   logic             w_ir_clip, w_red_clip;

   logic [ADC_W-1:0] r_ir_ac, r_red_ac, r_ir_dc, r_red_dc;
   logic             r_ir_clip, r_red_clip;

   // PUBLISH also accepts: that sample is sample 0 of the next window.
   assign w_accept = Sample_Valid & Settings_Locked & (r_state != ST_IDLE);
   assign w_start  = (r_cnt == '0);
   assign w_last   = w_accept & (r_cnt == '1);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (Settings_Locked) w_state_nxt = ST_ACCUM;
         ST_ACCUM:   if (!Settings_Locked) w_state_nxt = ST_IDLE;
                     else if (w_last)      w_state_nxt = ST_PUBLISH;
         ST_PUBLISH: w_state_nxt = Settings_Locked ? ST_ACCUM : ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Losing lock throws away the partial window; relock restarts at sample 0.
   always_ff @(posedge CLK) begin
      if (rst || !Settings_Locked) r_cnt <= '0;
      else if (w_accept)           r_cnt <= r_cnt + 1'b1;
   end

   ppg_channel_stats #(.ADC_W(ADC_W), .SUM_W(SUM_W)) u_ir (
      .CLK(CLK), .rst(rst), .i_start(w_start), .i_accept(w_accept),
      .i_sample(IR_ADC_Value), .o_max(w_ir_max), .o_min(w_ir_min),
      .o_sum(w_ir_sum), .o_clip(w_ir_clip)
   );

   ppg_channel_stats #(.ADC_W(ADC_W), .SUM_W(SUM_W)) u_red (
      .CLK(CLK), .rst(rst), .i_start(w_start), .i_accept(w_accept),
      .i_sample(RED_ADC_Value), .o_max(w_red_max), .o_min(w_red_min),
      .o_sum(w_red_sum), .o_clip(w_red_clip)
   );

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_ir_ac    <= '0;
         r_red_ac   <= '0;
         r_ir_dc    <= '0;
         r_red_dc   <= '0;
         r_ir_clip  <= 1'b0;
         r_red_clip <= 1'b0;
      end else if (w_last) begin
         r_ir_ac    <= w_ir_max - w_ir_min;
         r_red_ac   <= w_red_max - w_red_min;
         r_ir_dc    <= ADC_W'(w_ir_sum >> WIN_LOG2);
         r_red_dc   <= ADC_W'(w_red_sum >> WIN_LOG2);
         r_ir_clip  <= w_ir_clip;
         r_red_clip <= w_red_clip;
      end
   end

   assign Out_Valid = (r_state == ST_PUBLISH);
   assign Busy      = (r_state != ST_IDLE);
   assign IR_AC     = r_ir_ac;
   assign RED_AC    = r_red_ac;
   assign IR_DC     = r_ir_dc;
   assign RED_DC    = r_red_dc;
   assign IR_Clip   = r_ir_clip;
   assign RED_Clip  = r_red_clip;
endmodule

// File: tb/tb_ppg_window_stats.sv
// Randomized self-checking bench for ppg_window_stats against a queue-based window model.
module tb_ppg_window_stats;
   localparam int N = 256;

   logic       CLK, rst, Settings_Locked, Sample_Valid;
   logic [7:0] IR_ADC_Value, RED_ADC_Value;
   logic       Out_Valid, IR_Clip, RED_Clip, Busy;
   logic [7:0] IR_AC, RED_AC, IR_DC, RED_DC;

   ppg_window_stats dut (
      .CLK(CLK), .rst(rst), .Settings_Locked(Settings_Locked), .Sample_Valid(Sample_Valid),
      .IR_ADC_Value(IR_ADC_Value), .RED_ADC_Value(RED_ADC_Value), .Out_Valid(Out_Valid),
      .IR_AC(IR_AC), .RED_AC(RED_AC), .IR_DC(IR_DC), .RED_DC(RED_DC),
      .IR_Clip(IR_Clip), .RED_Clip(RED_Clip), .Busy(Busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   wire [33:0] obs = {IR_AC, IR_DC, RED_AC, RED_DC, IR_Clip, RED_Clip};

   int         n_chk = 0, n_fail = 0;
   logic [7:0] q_ir[$], q_red[$];
   logic       m_active = 1'b0;
   logic       e_ov, e_busy;
   logic [33:0] e_res;

   // {AC, DC, clip} of a complete window, straight from the definitions.
   function automatic logic [16:0] stats(input logic [7:0] q[$]);
      int mx, mn, sm;
      logic cl;
      mx = 0; mn = 255; sm = 0; cl = 1'b0;
      foreach (q[i]) begin
         if (q[i] > mx) mx = q[i];
         if (q[i] < mn) mn = q[i];
         sm += q[i];
         if (q[i] == 8'd0 || q[i] == 8'd255) cl = 1'b1;
      end
      return {8'(mx - mn), 8'(sm / N), cl};
   endfunction

   // Drive one cycle and advance the model. The block is active in a cycle
   // exactly when the previous edge saw lock high and no reset.
   task automatic step(input logic r, input logic l, input logic v,
                       input logic [7:0] ir, input logic [7:0] red);
      logic [16:0] si, sr;
      rst = r; Settings_Locked = l; Sample_Valid = v;
      IR_ADC_Value = ir; RED_ADC_Value = red;
      @(posedge CLK);
      e_ov = 1'b0;
      if (r) begin
         q_ir.delete(); q_red.delete();
         e_res = '0;
         m_active = 1'b0;
      end else begin
         if (m_active && l && v) begin
            q_ir.push_back(ir); q_red.push_back(red);
         end
         if (!l) begin
            q_ir.delete(); q_red.delete();
         end
         if (q_ir.size() == N) begin
            si = stats(q_ir); sr = stats(q_red);
            e_res = {si[16:9], si[8:1], sr[16:9], sr[8:1], si[0], sr[0]};
            e_ov = 1'b1;
            q_ir.delete(); q_red.delete();
         end
         m_active = l;
      end
      e_busy = m_active;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
         n_chk++;
         if (obs !== 34'd0 || Busy !== 1'b0 || Out_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: outs=%h busy=%b ov=%b, need all 0", obs, Busy, Out_Valid);
         end
      end
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
         n_chk++;
         if (obs !== 34'd0 || Busy !== 1'b0 || Out_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unlocked_idle cyc %0d: outs=%h busy=%b ov=%b, need all 0", i, obs, Busy, Out_Valid);
         end
      end
   endtask

   task automatic test_alternating();
      int n_ov = 0;
      step(1'b0, 1'b1, 1'b1, 8'd0, 8'd0);  // strobe in IDLE lock cycle must be dropped
      for (int i = 0; i < N; i++) begin
         step(1'b0, 1'b1, 1'b1, (i % 2 == 0) ? 8'd100 : 8'd200, 8'd128);
         if (Out_Valid) n_ov++;
         n_chk++;
         if (Out_Valid !== e_ov || Busy !== e_busy) begin
            n_fail++;
            $display("FAIL alt_ctl cyc %0d: ov=%b busy=%b, need %b %b", i, Out_Valid, Busy, e_ov, e_busy);
         end
      end
      n_chk++;
      if (!(Out_Valid === 1'b1 && n_ov == 1 && IR_AC === 8'd100 && IR_DC === 8'd150 &&
            RED_AC === 8'd0 && RED_DC === 8'd128 && IR_Clip === 1'b0 && RED_Clip === 1'b0)) begin
         n_fail++;
         $display("FAIL alt_result: ov=%b n=%0d ir_ac=%0d ir_dc=%0d red_ac=%0d red_dc=%0d clip=%b%b, need 1 1 100 150 0 128 00",
                  Out_Valid, n_ov, IR_AC, IR_DC, RED_AC, RED_DC, IR_Clip, RED_Clip);
      end
      step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      n_chk++;
      if (Out_Valid !== 1'b0 || obs !== e_res) begin
         n_fail++;
         $display("FAIL alt_hold: ov=%b outs=%h, need 0 %h", Out_Valid, obs, e_res);
      end
   endtask

   task automatic test_back_to_back();
      int ov_at[$];
      for (int i = 0; i < 2 * N; i++) begin
         step(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
         if (Out_Valid) ov_at.push_back(i);
         n_chk++;
         if (Out_Valid !== e_ov || obs !== e_res) begin
            n_fail++;
            $display("FAIL b2b cyc %0d: ov=%b outs=%h, need %b %h", i, Out_Valid, obs, e_ov, e_res);
         end
      end
      n_chk++;
      if (ov_at.size() != 2 || ov_at[0] != N - 1 || ov_at[1] != 2 * N - 1) begin
         n_fail++;
         $display("FAIL b2b_timing: %0d pulses first=%0d, need 2 at %0d,%0d",
                  ov_at.size(), (ov_at.size() > 0) ? ov_at[0] : -1, N - 1, 2 * N - 1);
      end
   endtask

   task automatic test_clip();
      int k;
      for (int w = 0; w < 2; w++) begin
         k = $urandom_range(1, N - 1);
         for (int i = 0; i < N; i++) begin
            while ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
            step(1'b0, 1'b1, 1'b1,
                 (i == 0) ? 8'd50 : (w == 0 && i == k) ? 8'd255 : 8'($urandom_range(50, 60)),
                 8'($urandom_range(50, 60)));
            n_chk++;
            if (Out_Valid !== e_ov || obs !== e_res) begin
               n_fail++;
               $display("FAIL clip_w%0d cyc %0d: ov=%b outs=%h, need %b %h", w, i, Out_Valid, obs, e_ov, e_res);
            end
         end
         n_chk++;
         if (w == 0 && !(Out_Valid === 1'b1 && IR_Clip === 1'b1 && IR_AC === 8'd205 && RED_Clip === 1'b0)) begin
            n_fail++;
            $display("FAIL clip_set: ov=%b ir_clip=%b ir_ac=%0d red_clip=%b, need 1 1 205 0", Out_Valid, IR_Clip, IR_AC, RED_Clip);
         end
         if (w == 1 && !(Out_Valid === 1'b1 && IR_Clip === 1'b0 && RED_Clip === 1'b0)) begin
            n_fail++;
            $display("FAIL clip_clear: ov=%b ir_clip=%b red_clip=%b, need 1 0 0", Out_Valid, IR_Clip, RED_Clip);
         end
      end
   endtask

   task automatic test_unlock();
      logic [33:0] held;
      step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      held = obs;
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
         n_chk++;
         if (Out_Valid !== 1'b0 || obs !== held || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL unlock_hold cyc %0d: ov=%b busy=%b outs=%h, need 0 0 %h", i, Out_Valid, Busy, obs, held);
         end
      end
      step(1'b0, 1'b1, 1'b1, 8'd7, 8'd7);  // relock cycle, strobe dropped
      for (int i = 0; i < N; i++) begin
         step(1'b0, 1'b1, 1'b1, 8'd80, 8'd80);
         n_chk++;
         if (Out_Valid !== e_ov || obs !== e_res) begin
            n_fail++;
            $display("FAIL relock cyc %0d: ov=%b outs=%h, need %b %h", i, Out_Valid, obs, e_ov, e_res);
         end
      end
      n_chk++;
      if (!(Out_Valid === 1'b1 && IR_DC === 8'd80 && RED_DC === 8'd80 && IR_AC === 8'd0 && RED_AC === 8'd0)) begin
         n_fail++;
         $display("FAIL relock_result: ov=%b dc=%0d/%0d ac=%0d/%0d, need 1 80/80 0/0", Out_Valid, IR_DC, RED_DC, IR_AC, RED_AC);
      end
   endtask

   task automatic test_mid_reset();
      step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      for (int i = 0; i < 150; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
      step(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
      n_chk++;
      if (obs !== 34'd0 || Busy !== 1'b0 || Out_Valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: outs=%h busy=%b ov=%b, need all 0", obs, Busy, Out_Valid);
      end
      step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
      for (int i = 0; i < N + 2; i++) begin
         step(1'b0, 1'b1, (i < N), 8'($urandom), 8'($urandom));
         n_chk++;
         if (Out_Valid !== e_ov || obs !== e_res || Busy !== e_busy) begin
            n_fail++;
            $display("FAIL post_reset cyc %0d: ov=%b busy=%b outs=%h, need %b %b %h", i, Out_Valid, Busy, obs, e_ov, e_busy, e_res);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 999) == 0), ($urandom_range(0, 299) != 0),
              ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom));
         n_chk++;
         if (Out_Valid !== e_ov || obs !== e_res || Busy !== e_busy) begin
            n_fail++;
            $display("FAIL random cyc %0d: ov=%b busy=%b outs=%h, need %b %b %h", i, Out_Valid, Busy, obs, e_ov, e_busy, e_res);
         end
      end
   endtask

   initial begin
      rst = 1'b1; Settings_Locked = 1'b0; Sample_Valid = 1'b0;
      IR_ADC_Value = '0; RED_ADC_Value = '0;
      test_reset();
      test_alternating();
      test_back_to_back();
      test_clip();
      test_unlock();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
